// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous 16-bit memory between the instruction-fetch
//   (IF) port and the data-memory (DM) port. One transaction is in flight at a time,
//   sequenced IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP, with RESP able to
//   re-arbitrate straight into ISSUE for back-to-back service.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     undefined : DM has priority; IF is forced through after STARVE_MAX
//                 consecutive contended DM wins.
//     defined   : strict IF/DM alternation under contention via a last-grant pointer.
//
//   All outputs are registered and cleared asynchronously by rst (active low).
module mem_port_arbiter #(
   parameter int MEM_LAT    = 1,   // 1..7, mem_en cycle to valid mem_rdata
   parameter int STARVE_MAX = 4    // 1..15, contended DM wins before IF is forced
) (
   input  logic        clk,
   input  logic        rst,
   // instruction-fetch port (read only)
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [15:0] if_rdata,
   // data-memory port
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [15:0] dm_addr,
   input  logic [15:0] dm_wdata,
   output logic        dm_gnt,
   output logic        dm_rvalid,
   output logic [15:0] dm_rdata,
   // memory side
   output logic        mem_en,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t     state, state_nxt;
   logic [2:0] wait_cnt;     // remaining WAIT cycles after the current one
   logic       cur_dm;       // in-flight transaction belongs to DM
   logic       cur_we;       // in-flight transaction is a write
   logic       arb;          // arbitration happens at this edge
   logic       pick_dm;      // winner if arbitration happens now
   logic       wait_done;    // last WAIT cycle: read data is on mem_rdata

`ifdef ARB_ROUND_ROBIN_EN
   logic       last_if;      // last grant went to IF (reset: DM, so IF wins first contention)
`else
   logic [3:0] starve_cnt;   // consecutive contended DM wins since IF was last granted
`endif

   // Winner selection: a lone requester always wins; contention uses the policy below
   always_comb begin
      pick_dm = 1'b0;
      if (dm_req) begin
         if (!if_req) begin
            pick_dm = 1'b1;
         end else begin
`ifdef ARB_ROUND_ROBIN_EN
            pick_dm = last_if;
`else
            pick_dm = (starve_cnt != 4'(STARVE_MAX));
`endif
         end
      end
   end

   // Next-state logic; requests are only looked at in IDLE and RESP
   always_comb begin
      state_nxt = state;
      arb       = 1'b0;
      wait_done = 1'b0;
      case (state)
         IDLE: begin
            if (if_req || dm_req) begin
               arb       = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            state_nxt = WAIT;
         end
         WAIT: begin
            if (wait_cnt == 3'd0) begin
               wait_done = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (if_req || dm_req) begin
               arb       = 1'b1;
               state_nxt = ISSUE;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // WAIT length counter, loaded as ISSUE hands over to WAIT
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt <= 3'd0;
      end else if (state == ISSUE) begin
         wait_cnt <= 3'(MEM_LAT - 1);
      end else if (state == WAIT && wait_cnt != 3'd0) begin
         wait_cnt <= wait_cnt - 3'd1;
      end
   end

   // Remember who owns the in-flight transaction and whether it is a write
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_dm <= 1'b0;
         cur_we <= 1'b0;
      end else if (arb) begin
         cur_dm <= pick_dm;
         cur_we <= pick_dm && dm_we;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Last-grant pointer flips to whoever is granted, on every grant
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     last_if <= 1'b0;
      else if (arb) last_if <= !pick_dm;
   end
`else
   // Starvation guard: count contended DM wins, clear on any IF grant, saturate
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= 4'd0;
      end else if (arb) begin
         if (!pick_dm)
            starve_cnt <= 4'd0;
         else if (if_req && starve_cnt != 4'(STARVE_MAX))
            starve_cnt <= starve_cnt + 4'd1;
      end
   end
`endif

   // Grant pulse and memory command are launched together for the ISSUE cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_gnt    <= 1'b0;
         dm_gnt    <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 16'h0000;
         mem_wdata <= 16'h0000;
      end else begin
         if_gnt <= arb && !pick_dm;
         dm_gnt <= arb && pick_dm;
         mem_en <= arb;
         mem_we <= arb && pick_dm && dm_we;
         if (arb)
            mem_addr <= pick_dm ? dm_addr : if_addr;
         if (arb && pick_dm && dm_we)
            mem_wdata <= dm_wdata;
      end
   end

   // Response: capture read data on the last WAIT edge; writes only acknowledge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;
         if_rdata  <= 16'h0000;
         dm_rdata  <= 16'h0000;
      end else begin
         if_rvalid <= wait_done && !cur_dm;
         dm_rvalid <= wait_done && cur_dm;
         if (wait_done && !cur_dm)
            if_rdata <= mem_rdata;
         if (wait_done && cur_dm && !cur_we)
            dm_rdata <= mem_rdata;
      end
   end

   // busy mirrors "not IDLE" for the cycle the state register is in
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy <= 1'b0;
      else      busy <= (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: randomized requesters on both ports, a behavioural
// memory on the memory side, and a transaction-level timing/arbitration model.
module tb_mem_port_arbiter;

   localparam int LAT  = 2;
   localparam int SMAX = 4;

   localparam int M_IDLE = 0;   // no new requests
   localparam int M_RAND = 1;   // random new requests on both ports
   localparam int M_CONT = 2;   // both ports always requesting
   localparam int M_DM   = 3;   // only DM raises new requests
   localparam int M_IF   = 4;   // only IF raises new requests

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_gnt, if_rvalid;
   logic [15:0] if_addr, if_rdata;
   logic        dm_req, dm_we, dm_gnt, dm_rvalid;
   logic [15:0] dm_addr, dm_wdata, dm_rdata;
   logic        mem_en, mem_we, busy;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata = 16'h0000;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Memory contents: untouched words read back a fixed function of their address
   function automatic logic [15:0] seed_val(input logic [15:0] a);
      return a ^ 16'h5A3C;
   endfunction

   // Physical memory driven by the DUT's memory port, MEM_LAT read pipeline;
   // mem_rdata carries junk whenever no read result is due
   logic [15:0] pmem [int];
   logic [15:0] pd [LAT];
   logic        pv [LAT];
   initial for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = 16'h0; end

   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) begin
         pd[i] = pd[i-1];
         pv[i] = pv[i-1];
      end
      pv[0] = mem_en && !mem_we;
      pd[0] = pmem.exists(int'(mem_addr)) ? pmem[int'(mem_addr)] : seed_val(mem_addr);
      if (mem_en && mem_we) pmem[int'(mem_addr)] = mem_wdata;
      mem_rdata <= pv[LAT-1] ? pd[LAT-1] : 16'($urandom);
   end

   // Reference model: cycle numbers of the expected grant and response of the
   // one transaction in flight, plus the reference memory image
   logic [15:0] rmem [int];
   int          free_at, gnt_cyc, rv_cyc;
   logic        g_dm, g_we;
   logic [15:0] g_addr, g_wdata, g_rdata;
   logic [15:0] exp_if_rdata, exp_dm_rdata;
`ifdef ARB_ROUND_ROBIN_EN
   logic        last_if;
`else
   int          streak;
`endif
   logic        keep_if;
   int          last_dm_g;
   logic        dut_order [$];

   function automatic logic [15:0] rand_addr();
      return 16'($urandom_range(0, 31));
   endfunction

   task automatic model_reset();
      gnt_cyc      = -1000;
      rv_cyc       = -1000;
      exp_if_rdata = 16'h0;
      exp_dm_rdata = 16'h0;
      free_at      = cyc;
`ifdef ARB_ROUND_ROBIN_EN
      last_if = 1'b0;
`else
      streak  = 0;
`endif
   endtask

   // Raise new requests according to the stimulus mode (held ones are left alone)
   task automatic drive(input int mode);
      if (!if_req && (mode == M_CONT || mode == M_IF ||
                      (mode == M_RAND && $urandom_range(0, 2) == 0))) begin
         if_req  = 1'b1;
         if_addr = rand_addr();
      end
      if (!dm_req && (mode == M_CONT || mode == M_DM ||
                      (mode == M_RAND && $urandom_range(0, 2) == 0))) begin
         dm_req   = 1'b1;
         dm_we    = 1'($urandom_range(0, 1));
         dm_addr  = rand_addr();
         dm_wdata = 16'($urandom);
      end
   endtask

   // If the arbiter is free to sample this cycle, decide the winner by the policy rules
   task automatic arbitrate();
      logic wd;
      if (cyc >= free_at && (if_req || dm_req)) begin
         if (if_req && dm_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            wd = last_if;
`else
            wd = (streak != SMAX);
`endif
         end else begin
            wd = dm_req;
         end
`ifdef ARB_ROUND_ROBIN_EN
         last_if = !wd;
`else
         if (!wd)                        streak = 0;
         else if (if_req && streak < SMAX) streak++;
`endif
         g_dm    = wd;
         g_we    = wd && dm_we;
         g_addr  = wd ? dm_addr : if_addr;
         g_wdata = dm_wdata;
         if (g_we) rmem[int'(g_addr)] = g_wdata;
         else      g_rdata = rmem.exists(int'(g_addr)) ? rmem[int'(g_addr)] : seed_val(g_addr);
         gnt_cyc = cyc + 1;
         rv_cyc  = cyc + 2 + LAT;
         free_at = rv_cyc;
      end
   endtask

   // One cycle: check outputs at the falling edge, then update requesters and model
   task automatic step(input int mode);
      @(negedge clk);
      cyc++;
      if (cyc == rv_cyc && !g_we) begin
         if (g_dm) exp_dm_rdata = g_rdata;
         else      exp_if_rdata = g_rdata;
      end
      chk("if_gnt",    16'(if_gnt),    16'(cyc == gnt_cyc && !g_dm));
      chk("dm_gnt",    16'(dm_gnt),    16'(cyc == gnt_cyc && g_dm));
      chk("mem_en",    16'(mem_en),    16'(cyc == gnt_cyc));
      chk("mem_we",    16'(mem_we),    16'(cyc == gnt_cyc && g_we));
      if (cyc == gnt_cyc) begin
         chk("mem_addr", mem_addr, g_addr);
         if (g_we) chk("mem_wdata", mem_wdata, g_wdata);
      end
      chk("if_rvalid", 16'(if_rvalid), 16'(cyc == rv_cyc && !g_dm));
      chk("dm_rvalid", 16'(dm_rvalid), 16'(cyc == rv_cyc && g_dm));
      chk("if_rdata",  if_rdata, exp_if_rdata);
      chk("dm_rdata",  dm_rdata, exp_dm_rdata);
      chk("busy",      16'(busy), 16'(cyc >= gnt_cyc && cyc <= rv_cyc));
      if (if_gnt || dm_gnt) dut_order.push_back(dm_gnt);
      if (dm_gnt && mode == M_DM) begin
         if (last_dm_g > 0) chk("b2b_gap", 16'(cyc - last_dm_g), 16'(2 + LAT));
         last_dm_g = cyc;
      end
      if (cyc == gnt_cyc) begin
         if (g_dm)          dm_req = 1'b0;
         else if (!keep_if) if_req = 1'b0;
      end
      drive(mode);
      arbitrate();
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, {9'b0, if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy}, 16'h0);
      chk(tag, if_rdata | dm_rdata | mem_addr | mem_wdata, 16'h0);
   endtask

   // Two-cycle reset starting at a falling edge; held requests stay asserted
   task automatic do_reset(input int mode);
      rst = 1'b0;
      #1;
      chk_zero("rst_async");
      @(negedge clk); cyc++;
      chk_zero("rst_hold1");
      @(negedge clk); cyc++;
      chk_zero("rst_hold2");
      model_reset();
      rst = 1'b1;
      drive(mode);
      arbitrate();
   endtask

   initial begin
      logic       found;
      logic [5:0] order_got;
      logic [5:0] order_exp;
      rst = 1'b0;
      if_req = 1'b0; if_addr = 16'h0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = 16'h0; dm_wdata = 16'h0;
      keep_if = 1'b0;
      last_dm_g = 0;
      g_dm = 1'b0; g_we = 1'b0; g_addr = 16'h0; g_wdata = 16'h0; g_rdata = 16'h0;
      model_reset();

      // Reset state
      repeat (2) begin @(negedge clk); cyc++; end
      chk_zero("reset_state");
      rst = 1'b1;
      model_reset();

      // Mixed random traffic, with one reset landing at an arbitrary point
      for (int i = 0; i < 300; i++) step(M_RAND);
      do_reset(M_RAND);
      for (int i = 0; i < 300; i++) step(M_RAND);

      // Back-to-back DM service
      for (int i = 0; i < 20; i++) step(M_IDLE);
      last_dm_g = 0;
      for (int i = 0; i < 60; i++) step(M_DM);

      // Reset during WAIT of an IF read; the still-held request is served again
      for (int i = 0; i < 20; i++) step(M_IDLE);
      keep_if = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step(M_IF);
         if (cyc == gnt_cyc + 1 && !g_dm) found = 1'b1;
      end
      chk("t6_reach_wait", 16'(found), 16'h1);
      do_reset(M_IDLE);
      keep_if = 1'b0;
      for (int i = 0; i < 20; i++) step(M_IDLE);

      // Contention grant order from a fresh reset
      dut_order.delete();
      do_reset(M_CONT);
      for (int i = 0; i < 50; i++) step(M_CONT);
      chk("t4_order_len", 16'(dut_order.size() >= 6), 16'h1);
      order_got = 6'h0;
      for (int i = 0; i < 6 && i < dut_order.size(); i++) order_got[5-i] = dut_order[i];
`ifdef ARB_ROUND_ROBIN_EN
      order_exp = 6'b010101;   // IF,DM,IF,DM,IF,DM (1 = DM)
`else
      order_exp = 6'b111101;   // DM,DM,DM,DM,IF,DM (1 = DM)
`endif
      chk("t4_order", 16'(order_got), 16'(order_exp));

      // More random traffic, then drain
      for (int i = 0; i < 300; i++) step(M_RAND);
      for (int i = 0; i < 20; i++) step(M_IDLE);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
